// File: rtl/branch_stream_gen_if.sv
// Record stream between the branch-outcome generator and the predictor under test.
// The generator (master) presents pc/taken under out_valid; the consumer (slave)
// returns out_ready and its prediction for the record currently on the bus.
interface branch_stream_gen_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pc;
    logic       out_taken;
    logic       pred_taken;

    modport master (
        output out_valid,
        output out_pc,
        output out_taken,
        input  out_ready,
        input  pred_taken
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_taken,
        output out_ready,
        output pred_taken
    );
endinterface

// File: rtl/branch_stream_gen.sv
// branch_stream_gen: deterministic (pc, taken) record source for predictor tests.
// Sites are visited round-robin; each site follows a fixed pattern chosen by its
// index mod 4 (loop, alternate, always-taken, LFSR random).
// Optional feature: define BSG_SCOREBOARD_EN to sample pred_taken on every
// accepted record and count mispredicts; otherwise mispredict_count is zero.
module branch_stream_gen #(
    parameter int          NUM_BR    = 4,
    parameter int          LOOP_TRIP = 8,
    parameter int          LENGTH    = 1024,
    parameter logic [7:0]  PC_BASE   = 8'h40,
    parameter int          PC_STRIDE = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          branch_count,
    output logic [31:0]          mispredict_count,
    branch_stream_gen_if.master  bus
);

    localparam logic [7:0]  LOOP_LAST = 8'(LOOP_TRIP - 1);
    localparam logic [31:0] LAST_REC  = 32'(LENGTH - 1);
    localparam logic [3:0]  SITE_LAST = 4'(NUM_BR - 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  site_q, site_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] branch_count_q, branch_count_d;

    logic        valid;
    logic        launch;
    logic        hs;
    logic        last_hs;
    logic        rec_taken;
    logic [7:0]  rec_pc;

    logic [NUM_BR-1:0] site_taken;
    logic [7:0]        site_pc [NUM_BR];

    // A run is launched only from IDLE; start elsewhere has no effect.
    assign launch  = (state_q == S_IDLE) && start;
    assign hs      = valid && bus.out_ready;
    assign last_hs = hs && (branch_count_q == LAST_REC);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: run until the final record is accepted, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)   state_d = S_RUN;
            S_RUN:   if (last_hs) state_d = S_DONE;
            S_DONE:               state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status flags and the record-valid qualifier.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        valid = 1'b0;
        case (state_q)
            S_RUN: begin
                busy  = 1'b1;
                valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Site index sequencer: advances round-robin on each accepted record.
    always_comb begin
        site_d = site_q;
        if (launch) begin
            site_d = 4'd0;
        end else if (hs) begin
            site_d = (site_q == SITE_LAST) ? 4'd0 : site_q + 4'd1;
        end
    end

    // Site index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            site_q <= 4'd0;
        end else begin
            site_q <= site_d;
        end
    end

    // Galois LFSR next value: reseeded on launch, stepped only when a
    // random-pattern site (index mod 4 == 3) has its record accepted.
    always_comb begin
        lfsr_d = lfsr_q;
        if (launch) begin
            lfsr_d = LFSR_SEED;
        end else if (hs && (site_q[1:0] == 2'd3)) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Per-site state and outcome; the pattern is fixed at elaboration by gi mod 4.
    for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_site
        localparam logic [7:0] SITE_PC = 8'(int'(PC_BASE) + gi * PC_STRIDE);

        logic site_hs;

        assign site_pc[gi] = SITE_PC;
        assign site_hs     = hs && (site_q == 4'(gi));

        if ((gi % 4) == 0) begin : g_loop
            logic [7:0] loop_cnt_q, loop_cnt_d;

            // Loop counter: taken for the first LOOP_TRIP-1 visits, then not-taken and wrap.
            always_comb begin
                loop_cnt_d = loop_cnt_q;
                if (launch) begin
                    loop_cnt_d = 8'd0;
                end else if (site_hs) begin
                    loop_cnt_d = (loop_cnt_q == LOOP_LAST) ? 8'd0 : loop_cnt_q + 8'd1;
                end
            end

            // Loop counter register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    loop_cnt_q <= 8'd0;
                end else begin
                    loop_cnt_q <= loop_cnt_d;
                end
            end

            assign site_taken[gi] = (loop_cnt_q != LOOP_LAST);
        end else if ((gi % 4) == 1) begin : g_alt
            logic alt_q, alt_d;

            // Alternate flag: clear means the next visit is taken; toggles per visit.
            always_comb begin
                alt_d = alt_q;
                if (launch) begin
                    alt_d = 1'b0;
                end else if (site_hs) begin
                    alt_d = ~alt_q;
                end
            end

            // Alternate flag register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    alt_q <= 1'b0;
                end else begin
                    alt_q <= alt_d;
                end
            end

            assign site_taken[gi] = ~alt_q;
        end else if ((gi % 4) == 2) begin : g_always
            assign site_taken[gi] = 1'b1;
        end else begin : g_rand
            assign site_taken[gi] = lfsr_q[0];
        end
    end

    // Select the current site's record.
    always_comb begin
        rec_pc    = 8'h00;
        rec_taken = 1'b0;
        for (int i = 0; i < NUM_BR; i++) begin
            if (site_q == 4'(i)) begin
                rec_pc    = site_pc[i];
                rec_taken = site_taken[i];
            end
        end
    end

    // Record outputs read as zero whenever no record is being offered.
    assign bus.out_valid = valid;
    assign bus.out_pc    = valid ? rec_pc : 8'h00;
    assign bus.out_taken = valid & rec_taken;

    // Accepted-record counter: cleared on launch, held after the run for readout.
    always_comb begin
        branch_count_d = branch_count_q;
        if (launch) begin
            branch_count_d = 32'd0;
        end else if (hs) begin
            branch_count_d = branch_count_q + 32'd1;
        end
    end

    // Accepted-record counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q <= 32'd0;
        end else begin
            branch_count_q <= branch_count_d;
        end
    end

    assign branch_count = branch_count_q;

`ifdef BSG_SCOREBOARD_EN
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Mispredict counter: compares the consumer's prediction with the outcome on each accept.
    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (launch) begin
            mispredict_count_d = 32'd0;
        end else if (hs && (bus.pred_taken != rec_taken)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    // Mispredict counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count_q <= 32'd0;
        end else begin
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict_count = mispredict_count_q;
`else
    assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_stream_gen.sv
// Directed bench for branch_stream_gen: two instances, one for the 3-site pattern
// scenarios and one 4-site instance exercising the LFSR site and PC wrap.
module tb_branch_stream_gen;

    logic clk = 1'b0;
    logic reset;
    logic start3, start4;
    logic busy3, done3, busy4, done4;
    logic [31:0] bcnt3, mcnt3, bcnt4, mcnt4;

    int vectors = 0;
    int miscompares = 0;

`ifdef BSG_SCOREBOARD_EN
    localparam int EXP_MIS3 = 3;
    localparam int EXP_MIS4 = 5;
`else
    localparam int EXP_MIS3 = 0;
    localparam int EXP_MIS4 = 0;
`endif

    // Expected outcomes, bit k = record k.
    logic [11:0] exp_tk3 = 12'h9EF;
    logic [7:0]  exp_tk4 = 8'h4F;
    logic [7:0]  exp_pc4 [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};

    branch_stream_gen_if bus3 ();
    branch_stream_gen_if bus4 ();

    branch_stream_gen #(
        .NUM_BR(3), .LOOP_TRIP(4), .LENGTH(12),
        .PC_BASE(8'h40), .PC_STRIDE(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start3),
        .busy(busy3), .done(done3),
        .branch_count(bcnt3), .mispredict_count(mcnt3),
        .bus(bus3)
    );

    branch_stream_gen #(
        .NUM_BR(4), .LOOP_TRIP(2), .LENGTH(8),
        .PC_BASE(8'hF8), .PC_STRIDE(4), .LFSR_SEED(16'hACE1)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .busy(busy4), .done(done4),
        .branch_count(bcnt4), .mispredict_count(mcnt4),
        .bus(bus4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pc3(input int k);
        return 8'h40 + 8'(4 * (k % 3));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start3 = 1'b0;
        start4 = 1'b0;
        bus3.out_ready = 1'b1;
        bus3.pred_taken = 1'b1;
        bus4.out_ready = 1'b1;
        bus4.pred_taken = 1'b0;
        step();
        step();
        vectors++;
        if ({busy3, done3, bus3.out_valid, bus3.out_pc, bus3.out_taken} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_flags3: got busy=%b done=%b valid=%b pc=%h taken=%b, want all 0",
                     busy3, done3, bus3.out_valid, bus3.out_pc, bus3.out_taken);
        end
        vectors++;
        if ({bcnt3, mcnt3} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_counts3: got bc=%0d mc=%0d, want 0/0", bcnt3, mcnt3);
        end
        vectors++;
        if ({busy4, done4, bus4.out_valid, bus4.out_pc, bus4.out_taken, bcnt4} !== 44'd0) begin
            miscompares++;
            $display("FAIL reset_dut4: got busy=%b done=%b valid=%b pc=%h bc=%0d, want all 0",
                     busy4, done4, bus4.out_valid, bus4.out_pc, bcnt4);
        end
        reset = 1'b0;
        step();
    endtask

    // Full stall-free 12-record run on the 3-site instance.
    task automatic test_patterns();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            $display("rec %0d: pc=%h taken=%b bc=%0d", k, bus3.out_pc, bus3.out_taken, bcnt3);
            vectors++;
            if ({bus3.out_valid, busy3, bus3.out_pc, bus3.out_taken, bcnt3}
                    !== {1'b1, 1'b1, pc3(k), exp_tk3[k], 32'(k)}) begin
                miscompares++;
                $display("FAIL pattern_rec%0d: got valid=%b busy=%b pc=%h taken=%b bc=%0d, want 1 1 %h %b %0d",
                         k, bus3.out_valid, busy3, bus3.out_pc, bus3.out_taken, bcnt3,
                         pc3(k), exp_tk3[k], k);
            end
            step();
        end
        vectors++;
        if ({done3, busy3, bus3.out_valid, bcnt3, mcnt3} !== {3'b100, 32'd12, 32'(EXP_MIS3)}) begin
            miscompares++;
            $display("FAIL pattern_done: got done=%b busy=%b valid=%b bc=%0d mc=%0d, want 1 0 0 12 %0d",
                     done3, busy3, bus3.out_valid, bcnt3, mcnt3, EXP_MIS3);
        end
        step();
        vectors++;
        if ({done3, busy3, bcnt3, mcnt3} !== {2'b00, 32'd12, 32'(EXP_MIS3)}) begin
            miscompares++;
            $display("FAIL pattern_idle: got done=%b busy=%b bc=%0d mc=%0d, want 0 0 12 %0d",
                     done3, busy3, bcnt3, mcnt3, EXP_MIS3);
        end
    endtask

    // Consumer stalls for three cycles with record 5 on the bus.
    task automatic test_backpressure();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) begin
                bus3.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    $display("stall %0d: pc=%h taken=%b bc=%0d", s, bus3.out_pc, bus3.out_taken, bcnt3);
                    vectors++;
                    if ({bus3.out_valid, bus3.out_pc, bus3.out_taken, bcnt3}
                            !== {1'b1, pc3(5), exp_tk3[5], 32'd5}) begin
                        miscompares++;
                        $display("FAIL stall%0d: got valid=%b pc=%h taken=%b bc=%0d, want 1 %h %b 5",
                                 s, bus3.out_valid, bus3.out_pc, bus3.out_taken, bcnt3,
                                 pc3(5), exp_tk3[5]);
                    end
                end
                bus3.out_ready = 1'b1;
            end
            vectors++;
            if ({bus3.out_pc, bus3.out_taken} !== {pc3(k), exp_tk3[k]}) begin
                miscompares++;
                $display("FAIL bp_rec%0d: got pc=%h taken=%b, want %h %b",
                         k, bus3.out_pc, bus3.out_taken, pc3(k), exp_tk3[k]);
            end
            step();
        end
        vectors++;
        if ({done3, bcnt3, mcnt3} !== {1'b1, 32'd12, 32'(EXP_MIS3)}) begin
            miscompares++;
            $display("FAIL bp_final: got done=%b bc=%0d mc=%0d, want 1 12 %0d",
                     done3, bcnt3, mcnt3, EXP_MIS3);
        end
        step();
    endtask

    // Reset at record 6, then a fresh run must replay from site 0.
    task automatic test_reset_mid_run();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
        end
        vectors++;
        if ({bus3.out_pc, bcnt3} !== {pc3(6), 32'd6}) begin
            miscompares++;
            $display("FAIL pre_reset: got pc=%h bc=%0d, want %h 6", bus3.out_pc, bcnt3, pc3(6));
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({bus3.out_valid, busy3, done3, bcnt3, mcnt3} !== 67'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b busy=%b done=%b bc=%0d mc=%0d, want all 0",
                     bus3.out_valid, busy3, done3, bcnt3, mcnt3);
        end
        reset = 1'b0;
        step();
        test_patterns();
    endtask

    // start pulsed mid-run must not restart or extend the run.
    task automatic test_start_ignored();
        int dones;
        dones = 0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            start3 = (c == 4) || (c == 12);
            if (done3) dones++;
            step();
        end
        start3 = 1'b0;
        vectors++;
        if ({32'(dones), bcnt3, busy3} !== {32'd1, 32'd12, 1'b0}) begin
            miscompares++;
            $display("FAIL start_ignored: got dones=%0d bc=%0d busy=%b, want 1 12 0",
                     dones, bcnt3, busy3);
        end
    endtask

    // 4-site instance: LFSR site outcomes (T then N) and 8-bit PC wrap.
    task automatic test_lfsr();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            $display("rec4 %0d: pc=%h taken=%b", k, bus4.out_pc, bus4.out_taken);
            vectors++;
            if ({bus4.out_valid, bus4.out_pc, bus4.out_taken}
                    !== {1'b1, exp_pc4[k % 4], exp_tk4[k]}) begin
                miscompares++;
                $display("FAIL lfsr_rec%0d: got valid=%b pc=%h taken=%b, want 1 %h %b",
                         k, bus4.out_valid, bus4.out_pc, bus4.out_taken, exp_pc4[k % 4], exp_tk4[k]);
            end
            step();
        end
        vectors++;
        if ({done4, bcnt4, mcnt4} !== {1'b1, 32'd8, 32'(EXP_MIS4)}) begin
            miscompares++;
            $display("FAIL lfsr_final: got done=%b bc=%0d mc=%0d, want 1 8 %0d",
                     done4, bcnt4, mcnt4, EXP_MIS4);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_backpressure();
        test_reset_mid_run();
        test_start_ignored();
        test_lfsr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_stream_gen.md
# branch_stream_gen

Synthesizable branch-outcome source for the global-predictor test harness. It emits a deterministic stream of (pc, taken) records over a valid/ready handshake to a predictor under test, such as gshare. In a compiled-in option, it samples the predictor's prediction for each record and counts mispredicts. It replaces file-driven stimulus in on-chip and emulation runs.

## Interface
Parameters:
- NUM_BR, 4: number of branch sites visited round-robin (1..16).
- LOOP_TRIP, 8: loop-pattern period (2..255).
- LENGTH, 1024: records per run (1..2^31-1).
- PC_BASE, 8'h40: PC of site 0.
- PC_STRIDE, 4: PC increment per site, 8-bit wrap.
- LFSR_SEED, 16'hACE1: LFSR load value, must be non-zero.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts record.
- out_pc  out  8  branch PC.
- out_taken  out  1  resolved outcome.
- pred_taken  in  1  predictor output for the current record, sampled on handshake.
- branch_count  out  32  records accepted this run.
- mispredict_count  out  32  accepted records where pred_taken != out_taken.

## Operation
- FSM: IDLE -> RUN on start. RUN -> DONE on the handshake of record LENGTH-1. DONE -> IDLE unconditionally.
- Handshake: a record is accepted when out_valid && out_ready.
- On start, the block clears both counters, site index, per-site loop counters and alternate flags, and reloads the LFSR with LFSR_SEED.
- Site i has out_pc = PC_BASE + i*PC_STRIDE (mod 256). Sites advance i -> (i+1) mod NUM_BR on each handshake.
- Pattern selection is by i mod 4:
  - 0, loop: per-site counter c. Taken while c < LOOP_TRIP-1. Not-taken when c == LOOP_TRIP-1, then c wraps to 0.
  - 1, alternate: the first visit is taken, then the outcome toggles on each visit.
  - 2: always taken.
  - 3, random: out_taken = lfsr[0]. The LFSR is a 16-bit Galois register: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only on handshake of a pattern-3 record.
- Per-site state updates only on the handshake of that site's record.
- branch_count increments by 1 per handshake. No wrap is possible within the LENGTH bound.
- start while in RUN or DONE is ignored.

## Timing
- Reset values:
  - state IDLE
  - busy 0
  - done 0
  - out_valid 0
  - out_pc 8'h00
  - out_taken 0
  - both counts 0
  - LFSR loaded with LFSR_SEED
- Start latency: start is high in cycle N in IDLE. out_valid and busy are high in N+1, with the first record (site 0) on the outputs.
- Back-to-back: after a handshake in cycle N, the next record is presented in N+1 with out_valid held high. Peak rate is one record per cycle.
- Backpressure: while out_valid && !out_ready, out_pc and out_taken are stable, and no counter or state changes.
- Completion: the final handshake happens in cycle N. In N+1, out_valid=0, busy=0 and done=1. In N+2, done=0 and the FSM is in IDLE. The counts hold until the next start.
- Counters update at the clock edge ending the handshake cycle, so they are visible in the following cycle.
- Reset asserted mid-run: at the next edge all state returns to reset values. A partially transferred record is discarded.

## Configuration
- BSG_SCOREBOARD_EN defined: pred_taken is sampled on each handshake, and mispredict_count increments when pred_taken != out_taken.
- BSG_SCOREBOARD_EN undefined: pred_taken is unused, mispredict_count is tied to 32'd0 and no comparator is built. The rest of the behaviour is identical.

## Test plan
- Deterministic patterns: NUM_BR=3, LOOP_TRIP=4, LENGTH=12, out_ready=1, pred_taken=1, macro defined.
  - out_pc sequence is 40,44,48 repeated.
  - site0 T,T,T,N; site1 T,N,T,N; site2 T,T,T,T.
  - done pulses 13 cycles after start; branch_count=12, mispredict_count=3.
- LFSR: NUM_BR=4, site 3 records. The first two outcomes are T then N (LFSR values ACE1, E270).
- Backpressure: drop out_ready for 3 cycles at record 5. out_pc and out_taken are stable, branch_count holds at 5, and the final counts match the stall-free run.
- Reset mid-run: assert reset at record 6 of 12. Next cycle: out_valid=0, counts=0, busy=0. A restart replays the identical sequence from site 0.
- start during RUN is ignored: the run still ends at LENGTH records with a single done pulse.
- Macro undefined: same stimulus as the first scenario gives mispredict_count=0 and branch_count=12.
